// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the LED pulse stretcher (and its sibling debouncer):
// state encoding, counter width and default 50 MHz timing constants.
package pulse_stretch_pkg;

  localparam int CNT_W = 20;

  // Encoding chosen so that dout is state bit 0 and busy is the OR of both bits.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ON   = 2'b01;
  localparam logic [1:0] ST_OFF  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ON   = ST_ON,
    S_OFF  = ST_OFF
  } state_e;

  // 20 ms and 10 ms at 50 MHz.
  localparam logic [CNT_W-1:0] T_20MS = 20'hF_4240;
  localparam logic [CNT_W-1:0] T_10MS = 20'h7_A120;

endpackage

// File: rtl/pulse_stretch_dn_cnt_load.sv
// Loadable down counter with zero flag. Load has priority over decrement;
// the caller gates en so the count never wraps below zero.
module dn_cnt_load
  import pulse_stretch_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_r;

  // Count register: load a fresh window length or step down by one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_r <= {W{1'b0}};
    end else if (load) begin
      value_r <= load_val;
    end else if (en) begin
      value_r <= value_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;
  assign zero  = (value_r == {W{1'b0}});

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns 1-cycle event strobes into an ON window of T_ON
// cycles followed by a mandatory OFF gap of T_OFF cycles. One event may be
// queued while a window is running; further events are dropped and flagged.
// Optional build macro PULSE_STRETCH_RETRIGGER_EN: an event during ON
// restarts the ON window instead of being queued.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_ON  = T_20MS,
  parameter logic [CNT_W-1:0] T_OFF = T_10MS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] T_ON_LD  = T_ON - CNT_ONE;
  localparam logic [CNT_W-1:0] T_OFF_LD = T_OFF - CNT_ONE;

  state_e           state_r;
  state_e           state_nxt_s;
  logic             pending_r;
  logic             pending_nxt_s;
  logic             drop_r;
  logic             drop_nxt_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_zero_s;
  logic             last_s;

  // The zero flag guards the decrement (no wrap); the value decides when a
  // window has run out.
  assign last_s = (cnt_s == {CNT_W{1'b0}});

  dn_cnt_load #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load_s),
    .en       (cnt_en_s),
    .load_val (load_val_s),
    .value    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, counter control, pending queue and drop decision.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    drop_nxt_s    = 1'b0;
    load_s        = 1'b0;
    load_val_s    = T_ON_LD;
    cnt_en_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (din) begin
          state_nxt_s = S_ON;
          load_s      = 1'b1;
          load_val_s  = T_ON_LD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ON: begin
        cnt_en_s = ~cnt_zero_s;
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (din) begin
          // Extend the running blink; nothing is queued or dropped.
          state_nxt_s = S_ON;
          load_s      = 1'b1;
          load_val_s  = T_ON_LD;
        end else if (last_s) begin
          state_nxt_s = S_OFF;
          load_s      = 1'b1;
          load_val_s  = T_OFF_LD;
        end else begin
          state_nxt_s = S_ON;
        end
`else
        if (din && pending_r) begin
          drop_nxt_s = 1'b1;
        end else if (din) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
        if (last_s) begin
          state_nxt_s = S_OFF;
          load_s      = 1'b1;
          load_val_s  = T_OFF_LD;
        end else begin
          state_nxt_s = S_ON;
        end
`endif
      end
      S_OFF: begin
        cnt_en_s = ~cnt_zero_s;
        if (last_s) begin
          // Gap complete: a queued or same-cycle event starts the next blink.
          if (pending_r || din) begin
            state_nxt_s   = S_ON;
            load_s        = 1'b1;
            load_val_s    = T_ON_LD;
            pending_nxt_s = 1'b0;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else if (din && pending_r) begin
          drop_nxt_s = 1'b1;
        end else if (din) begin
          pending_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_OFF;
        end
      end
      default: begin
        state_nxt_s   = S_IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pending flag and drop pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= S_IDLE;
      pending_r <= 1'b0;
      drop_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      drop_r    <= drop_nxt_s;
    end
  end

  // Outputs come straight from register bits, so they cannot glitch.
  assign dout = state_r[0];
  assign busy = state_r[0] | state_r[1];
  assign drop = drop_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch with T_ON=4, T_OFF=2.
// The expected outputs come from an interval model: each blink is a window
// [on_s..on_e] ON followed by (on_e..off_e] OFF, plus a one-deep event queue.
module tb_pulse_stretch;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int NCYC  = 40;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic din   = 1'b0;
  logic dout;
  logic busy;
  logic drop;

  always #5 clk = ~clk;

  pulse_stretch #(
    .T_ON  (20'd4),
    .T_OFF (20'd2)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .din   (din),
    .dout  (dout),
    .busy  (busy),
    .drop  (drop)
  );

  int total    = 0;
  int bad      = 0;
  int cur_cyc  = 0;
  int cur_test = 0;
  bit check_en = 1'b0;

  // Model state.
  bit m_act;
  bit m_pend;
  int m_on_s;
  int m_on_e;
  int m_off_e;
  int m_drop_at;

  typedef struct {
    int t;
    int c;
    int sig;  // 0 dout, 1 busy, 2 drop
    bit v;
  } pin_t;
  pin_t pins[$];

  task automatic check(input string name, input int c, input bit act, input bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s test=%0d cyc=%0d got=%0b want=%0b", name, cur_test, c, act, exp);
    end
  endtask

  task automatic start_window(input int s);
    m_act   = 1'b1;
    m_on_s  = s;
    m_on_e  = s + T_ON - 1;
    m_off_e = m_on_e + T_OFF;
  endtask

  function automatic void add_pin(input int t, input int c, input int sig, input bit v);
    pin_t p;
    p.t = t; p.c = c; p.sig = sig; p.v = v;
    pins.push_back(p);
  endfunction

  // Compare DUT against the model and pinned literals, then advance the model.
  always @(negedge clk) begin : cmp
    int  c;
    bit  e_dout, e_busy, e_drop, in_on, in_off;
    if (check_en) begin
      c = cur_cyc;
      if (!n_rst) begin
        e_dout = 1'b0; e_busy = 1'b0; e_drop = 1'b0;
      end else begin
        e_dout = m_act && (c >= m_on_s) && (c <= m_on_e);
        e_busy = m_act && (c >= m_on_s) && (c <= m_off_e);
        e_drop = (m_drop_at == c);
      end
      check("dout", c, dout, e_dout);
      check("busy", c, busy, e_busy);
      check("drop", c, drop, e_drop);
      foreach (pins[i]) begin
        if (pins[i].t == cur_test && pins[i].c == c) begin
          case (pins[i].sig)
            0: check("pin_dout", c, dout, pins[i].v);
            1: check("pin_busy", c, busy, pins[i].v);
            default: check("pin_drop", c, drop, pins[i].v);
          endcase
        end
      end
      if (!n_rst) begin
        m_act = 1'b0; m_pend = 1'b0; m_drop_at = -1;
      end else begin
        in_on  = m_act && (c >= m_on_s) && (c <= m_on_e);
        in_off = m_act && (c > m_on_e) && (c <= m_off_e);
        if (!in_on && !in_off) begin
          if (din) start_window(c + 1);
        end else if (in_on) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          if (din) begin
            m_on_e  = c + T_ON;
            m_off_e = m_on_e + T_OFF;
          end
`else
          if (din) begin
            if (m_pend) m_drop_at = c + 1;
            else m_pend = 1'b1;
          end
`endif
        end else begin
          if (c == m_off_e) begin
            if (m_pend || din) begin
              start_window(c + 1);
              m_pend = 1'b0;
            end else begin
              m_act = 1'b0;
            end
          end else if (din) begin
            if (m_pend) m_drop_at = c + 1;
            else m_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_test(input int t, input bit [63:0] m, input int rlo, input int rhi);
    cur_test = t;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cur_cyc  = c;
      n_rst    = !((c < 2) || (c >= rlo && c < rhi));
      din      = m[c];
      check_en = 1'b1;
    end
    @(posedge clk);
    #1;
    check_en = 1'b0;
    din      = 1'b0;
  endtask

  initial begin : stim
    bit [63:0] m;
    m_act = 1'b0; m_pend = 1'b0; m_drop_at = -1;
    m_on_s = 0; m_on_e = 0; m_off_e = 0;

    // Hand-computed anchors for the single-event blink.
    add_pin(0, 10, 0, 1'b0); add_pin(0, 11, 0, 1'b1); add_pin(0, 14, 0, 1'b1);
    add_pin(0, 15, 0, 1'b0); add_pin(0, 16, 1, 1'b1); add_pin(0, 17, 1, 1'b0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    add_pin(6, 17, 0, 1'b1); add_pin(6, 18, 0, 1'b0);
    add_pin(6, 19, 1, 1'b1); add_pin(6, 20, 1, 1'b0);
`else
    add_pin(1, 17, 0, 1'b1); add_pin(1, 20, 0, 1'b1);
    add_pin(1, 21, 0, 1'b0); add_pin(1, 23, 1, 1'b0);
    add_pin(2, 13, 2, 1'b0); add_pin(2, 14, 2, 1'b1); add_pin(2, 15, 2, 1'b0);
    add_pin(3, 16, 0, 1'b0); add_pin(3, 17, 0, 1'b1);
    add_pin(5, 9, 2, 1'b1);  add_pin(5, 10, 0, 1'b0);
    add_pin(5, 11, 1, 1'b1); add_pin(5, 12, 0, 1'b1); add_pin(5, 12, 2, 1'b0);
`endif
    add_pin(4, 12, 0, 1'b0); add_pin(4, 12, 1, 1'b0); add_pin(4, 13, 1, 1'b0);
    add_pin(4, 21, 0, 1'b1); add_pin(4, 24, 0, 1'b1);
    add_pin(4, 25, 0, 1'b0); add_pin(4, 27, 1, 1'b0);

    m = '0; m[10] = 1'b1;                          run_test(0, m, 0, 0);
    m = '0; m[10] = 1'b1; m[12] = 1'b1;            run_test(1, m, 0, 0);
    m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1; run_test(2, m, 0, 0);
    m = '0; m[10] = 1'b1; m[16] = 1'b1;            run_test(3, m, 0, 0);
    m = '0; m[10] = 1'b1; m[20] = 1'b1;            run_test(4, m, 12, 14);
    m = '0; for (int i = 5; i <= 30; i++) m[i] = 1'b1;
    run_test(5, m, 0, 0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    m = '0; m[10] = 1'b1; m[13] = 1'b1;            run_test(6, m, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
Output-side counterpart to our button debouncer. The debouncer filters short input glitches; this block stretches short internal event pulses into human-visible LED blinks.
- Each accepted event produces a fixed ON window followed by a mandatory OFF gap.
- Back-to-back events therefore stay distinguishable.
- Sits between control logic (1-cycle strobes) and board LED pins.

Parameters:
- T_ON, 20'hF_4240, ON window length in clk cycles (20 ms at 50 MHz); must be >= 1.
- T_OFF, 20'h7_A120, OFF gap length in clk cycles (10 ms at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- din  input  1  event strobe; every cycle sampled high counts as one event; synchronous to clk.
- dout  output  1  stretched LED drive; registered.
- busy  output  1  high whenever state != IDLE.
- drop  output  1  1-cycle registered pulse: event discarded.

Behaviour:
- Reset (async, n_rst low): state=IDLE, cnt=0, pending=0, dout=0, drop=0. Takes effect immediately, including mid-blink; no partial window resumes.
- Counter: 20-bit down counter, loaded with T-1 on state entry; no wrap (never decremented below 0).
- IDLE, din=0: stay.
- IDLE, din=1: next cycle ON, cnt=T_ON-1.
- ON: dout=1; cnt decrements each cycle.
  - din=1 in ON: pending<=1 (no RETRIGGER_EN).
  - cnt==0: next OFF, cnt=T_OFF-1.
- OFF: dout=0; cnt decrements each cycle.
  - din=1 in OFF: pending<=1.
  - cnt==0 and (pending or din): next ON, cnt=T_ON-1, pending<=0.
  - cnt==0 otherwise: next IDLE.
- Latency: din sampled at edge N gives dout high from cycle N+1. A single event gives exactly T_ON high cycles, then T_OFF low cycles, with busy high for T_ON+T_OFF cycles.
- Pending queue depth is one. din=1 while pending already 1, and not consumed that cycle: drop=1 the following cycle; the event is lost.
- din=1 on the same cycle pending is consumed (OFF, cnt==0) merges into that transition; no drop.
- din held high continuously: repeated blink pattern ON/OFF with drop pulses. Legal, not an error.
- dout and busy are decoded from registered state bits only, so they are glitch-free.

Optional Feature:
- Macro PULSE_STRETCH_RETRIGGER_EN.
- Defined: din=1 in ON reloads cnt=T_ON-1, extending the current blink. Pending is not set, and drop is never asserted from ON. din in OFF still sets pending.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package pulse_stretch_pkg:
  - state encoding localparams ST_IDLE, ST_ON, ST_OFF (2-bit).
  - CNT_W=20.
  - Default timing constants T_20MS=20'hF_4240, T_10MS=20'h7_A120, for reuse with the debouncer.
- One natural sub-module: dn_cnt_load, a CNT_W-bit loadable down counter with load, value and zero flag. The FSM, pending and drop logic stay in the top.

Test Plan (T_ON=4, T_OFF=2):
- din pulse at cycle 10 -> dout high 11-14, low 15-16; busy high 11-16, low from 17; drop never asserted.
- din at 10 and 12 -> dout high 11-14, low 15-16, high 17-20, low 21-22; busy low from 23.
- din at 10, 12, 13 -> drop high at cycle 14 only; exactly two blinks as in previous case.
- din at 10, then din at 16 (last OFF cycle, pending=0) -> second ON starts at 17 with no extra gap; dout high 17-20.
- n_rst low at cycle 12 (mid-ON), released at 14 -> dout/busy 0 from the reset assertion. din at 20 -> fresh blink 21-24; no residual pending blink.
- PULSE_STRETCH_RETRIGGER_EN defined, din at 10 and 13 -> dout high 11-17, low 18-19, drop never asserted.
